// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths, arbiter state encoding and constants for the register file write scheduler.
package regfile_write_scheduler_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);

  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_write_scheduler_scoreboard.sv
// Busy-register scoreboard for outstanding MDU results, pending counter and ID hazard detection.
module regfile_scoreboard
  import regfile_write_scheduler_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_reg_i,
  input  logic [ADDR_W-1:0] check_reg1_i,
  input  logic [ADDR_W-1:0] check_reg2_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_reg_i,
  input  logic              xfer_i,
  input  logic [ADDR_W-1:0] xfer_reg_i,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  pending_count_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_c;
  logic                hazard_c;
  logic                issue_ok_c;

  assign full_c = (count_q >= CNT_W'(MAX_PENDING));

  // Bit 0 is never set, so register 0 can never raise a hazard.
  always_comb begin
    hazard_c = busy_q[check_reg1_i] | busy_q[check_reg2_i]
             | (issue_valid_i & full_c)
             | (wb_valid_i & busy_q[wb_reg_i]);
  end

  assign issue_ok_c = issue_valid_i & ~hazard_c & ~full_c;

  // Clear on retire first so a same-register issue in the same cycle wins.
  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (xfer_i) begin
      busy_d[xfer_reg_i] = 1'b0;
    end
    if (issue_ok_c) begin
      busy_d[issue_reg_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    case ({issue_ok_c, xfer_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = (count_q != '0) ? count_q - 1'b1 : count_q;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign hazard_stall_o  = hazard_c;
  assign pending_count_o = count_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register file write port between WB and the MDU, with a starvation guard.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_PENDING  = 4
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              wbValid,
  input  logic [ADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0] wbData,
  input  logic              mduValid,
  input  logic [ADDR_W-1:0] mduReg,
  input  logic [DATA_W-1:0] mduData,
  output logic              mduReady,
  input  logic              issueValid,
  input  logic [ADDR_W-1:0] issueReg,
  input  logic [ADDR_W-1:0] checkReg1,
  input  logic [ADDR_W-1:0] checkReg2,
  output logic              hazardStall,
  output logic              wbStall,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic [CNT_W-1:0]  pendingCount
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                regwrite_q;
  logic [ADDR_W-1:0]   writereg_q;
  logic [DATA_W-1:0]   writedata_q;
  logic                wbstall_q;

  logic                mdu_ready_c;
  logic                win_c;
  logic [ADDR_W-1:0]   win_reg_c;
  logic [DATA_W-1:0]   win_data_c;

  // Arbiter next-state and winner selection.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mdu_ready_c = 1'b0;
    win_c       = 1'b0;
    win_reg_c   = wbReg;
    win_data_c  = wbData;
    case (state_q)
      ARB: begin
        if (wbValid) begin
          win_c = 1'b1;
          if (mduValid) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
              state_d = FORCE;
            end
            if (starve_q != '1) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end else if (mduValid) begin
          mdu_ready_c = 1'b1;
          win_c       = 1'b1;
          win_reg_c   = mduReg;
          win_data_c  = mduData;
          starve_d    = '0;
        end
      end
      FORCE: begin
        state_d     = ARB;
        starve_d    = '0;
        mdu_ready_c = mduValid;
        if (mduValid) begin
          win_c      = 1'b1;
          win_reg_c  = mduReg;
          win_data_c = mduData;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Write port register: data holds when idle, register 0 suppresses the strobe.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      wbstall_q   <= 1'b0;
    end else begin
      regwrite_q <= win_c & (win_reg_c != REG_ZERO);
      wbstall_q  <= (state_d == FORCE);
      if (win_c) begin
        writereg_q  <= win_reg_c;
        writedata_q <= win_data_c;
      end
    end
  end

  regfile_scoreboard #(
    .MAX_PENDING(MAX_PENDING)
  ) u_scoreboard (
    .clk            (clock_in),
    .rst_n          (reset_n),
    .issue_valid_i  (issueValid),
    .issue_reg_i    (issueReg),
    .check_reg1_i   (checkReg1),
    .check_reg2_i   (checkReg2),
    .wb_valid_i     (wbValid),
    .wb_reg_i       (wbReg),
    .xfer_i         (mdu_ready_c & mduValid),
    .xfer_reg_i     (mduReg),
    .hazard_stall_o (hazardStall),
    .pending_count_o(pendingCount)
  );

  assign mduReady  = mdu_ready_c;
  assign wbStall   = wbstall_q;
  assign regWrite  = regwrite_q;
  assign writeReg  = writereg_q;
  assign writeData = writedata_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with hand-computed expectations.
module tb_regfile_write_scheduler;

  logic        clock_in;
  logic        reset_n;
  logic        wbValid;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        mduValid;
  logic [4:0]  mduReg;
  logic [31:0] mduData;
  logic        mduReady;
  logic        issueValid;
  logic [4:0]  issueReg;
  logic [4:0]  checkReg1;
  logic [4:0]  checkReg2;
  logic        hazardStall;
  logic        wbStall;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [2:0]  pendingCount;

  int vectors;
  int miscompares;

  regfile_write_scheduler #(
    .STARVE_LIMIT(4),
    .MAX_PENDING (4)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .wbValid     (wbValid),
    .wbReg       (wbReg),
    .wbData      (wbData),
    .mduValid    (mduValid),
    .mduReg      (mduReg),
    .mduData     (mduData),
    .mduReady    (mduReady),
    .issueValid  (issueValid),
    .issueReg    (issueReg),
    .checkReg1   (checkReg1),
    .checkReg2   (checkReg2),
    .hazardStall (hazardStall),
    .wbStall     (wbStall),
    .regWrite    (regWrite),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .pendingCount(pendingCount)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n    = 1'b0;
    wbValid    = 1'b0;
    wbReg      = '0;
    wbData     = '0;
    mduValid   = 1'b0;
    mduReg     = '0;
    mduData    = '0;
    issueValid = 1'b0;
    issueReg   = '0;
    checkReg1  = '0;
    checkReg2  = '0;
    tick();
    tick();
    check("rst_regWrite", 32'(regWrite), 32'd0);
    check("rst_writeReg", 32'(writeReg), 32'd0);
    check("rst_writeData", writeData, 32'd0);
    check("rst_wbStall", 32'(wbStall), 32'd0);
    check("rst_pending", 32'(pendingCount), 32'd0);
    check("rst_hazard", 32'(hazardStall), 32'd0);
    reset_n = 1'b1;
    tick();

    // WB alone, then WB to register 0
    wbValid = 1'b1; wbReg = 5'b10101; wbData = 32'hFFFF0000;
    #1 check("wb_mduReady_idle", 32'(mduReady), 32'd0);
    tick();
    check("wb_regWrite", 32'(regWrite), 32'd1);
    check("wb_writeReg", 32'(writeReg), 32'd21);
    check("wb_writeData", writeData, 32'hFFFF0000);
    wbReg = 5'd0; wbData = 32'h00001234;
    tick();
    check("wb_r0_regWrite", 32'(regWrite), 32'd0);
    wbValid = 1'b0;
    tick();
    check("idle_regWrite", 32'(regWrite), 32'd0);

    // Scoreboard issue, RAW hazard, MDU retire
    issueValid = 1'b1; issueReg = 5'd10;
    #1 check("sb_issue_nohaz", 32'(hazardStall), 32'd0);
    tick();
    issueValid = 1'b0; checkReg1 = 5'd10;
    #1 check("sb_raw_hazard", 32'(hazardStall), 32'd1);
    check("sb_pending1", 32'(pendingCount), 32'd1);
    mduValid = 1'b1; mduReg = 5'd10; mduData = 32'h0000FFFF;
    #1 check("sb_mduReady", 32'(mduReady), 32'd1);
    tick();
    mduValid = 1'b0;
    check("sb_mdu_regWrite", 32'(regWrite), 32'd1);
    check("sb_mdu_writeReg", 32'(writeReg), 32'd10);
    check("sb_mdu_writeData", writeData, 32'h0000FFFF);
    check("sb_hazard_clear", 32'(hazardStall), 32'd0);
    check("sb_pending0", 32'(pendingCount), 32'd0);
    checkReg1 = 5'd0;

    // WAW hazard on register 12
    issueValid = 1'b1; issueReg = 5'd12;
    tick();
    issueValid = 1'b0; wbValid = 1'b1; wbReg = 5'd12; wbData = 32'h0;
    #1 check("waw_hazard", 32'(hazardStall), 32'd1);
    wbValid = 1'b0;
    #1 check("waw_clear_nowb", 32'(hazardStall), 32'd0);
    mduValid = 1'b1; mduReg = 5'd12; mduData = 32'h0000000C;
    tick();
    mduValid = 1'b0;
    check("waw_retire_pending", 32'(pendingCount), 32'd0);

    // Starvation guard: four lost cycles, one forced MDU cycle
    issueValid = 1'b1; issueReg = 5'd7;
    tick();
    issueValid = 1'b0;
    mduValid = 1'b1; mduReg = 5'd7; mduData = 32'h00000077;
    wbValid = 1'b1; wbReg = 5'd3;
    for (int i = 0; i < 4; i++) begin
      wbData = 32'hA0 + 32'(i);
      #1 check("starve_mduReady_low", 32'(mduReady), 32'd0);
      check("starve_wbStall_low", 32'(wbStall), 32'd0);
      tick();
      check("starve_wb_writeReg", 32'(writeReg), 32'd3);
      check("starve_wb_writeData", writeData, 32'hA0 + 32'(i));
    end
    wbData = 32'hB0;
    #1 check("force_wbStall", 32'(wbStall), 32'd1);
    check("force_mduReady", 32'(mduReady), 32'd1);
    tick();
    mduValid = 1'b0;
    check("force_writeReg", 32'(writeReg), 32'd7);
    check("force_writeData", writeData, 32'h00000077);
    check("force_regWrite", 32'(regWrite), 32'd1);
    check("force_wbStall_done", 32'(wbStall), 32'd0);
    check("force_pending", 32'(pendingCount), 32'd0);
    tick();
    check("resume_wb_writeReg", 32'(writeReg), 32'd3);
    check("resume_wb_writeData", writeData, 32'hB0);
    wbValid = 1'b0;

    // Fill the scoreboard to MAX_PENDING
    for (int r = 1; r <= 4; r++) begin
      issueValid = 1'b1; issueReg = 5'(r);
      tick();
    end
    check("full_pending4", 32'(pendingCount), 32'd4);
    issueReg = 5'd5;
    #1 check("full_issue_hazard", 32'(hazardStall), 32'd1);
    tick();
    check("full_pending_stays4", 32'(pendingCount), 32'd4);
    mduValid = 1'b1; mduReg = 5'd1; mduData = 32'h00001111;
    #1 check("full_simul_hazard", 32'(hazardStall), 32'd1);
    check("full_simul_mduReady", 32'(mduReady), 32'd1);
    tick();
    issueValid = 1'b0; mduValid = 1'b0;
    check("full_simul_pending3", 32'(pendingCount), 32'd3);
    check("full_simul_writeReg", 32'(writeReg), 32'd1);
    checkReg1 = 5'd5;
    #1 check("full_blocked_not_busy", 32'(hazardStall), 32'd0);
    checkReg2 = 5'd2;
    #1 check("full_busy2", 32'(hazardStall), 32'd1);
    checkReg1 = 5'd0; checkReg2 = 5'd0;

    // Asynchronous reset in the middle of a cycle
    issueValid = 1'b1; issueReg = 5'd8;
    wbValid = 1'b1; wbReg = 5'd9; wbData = 32'h99;
    tick();
    issueValid = 1'b0; wbValid = 1'b0; checkReg1 = 5'd8;
    #1 check("prerst_pending4", 32'(pendingCount), 32'd4);
    check("prerst_regWrite", 32'(regWrite), 32'd1);
    check("prerst_busy8", 32'(hazardStall), 32'd1);
    #1 reset_n = 1'b0;
    #1 check("arst_regWrite", 32'(regWrite), 32'd0);
    check("arst_pending", 32'(pendingCount), 32'd0);
    check("arst_busy8", 32'(hazardStall), 32'd0);
    check("arst_writeData", writeData, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("postrst_busy8", 32'(hazardStall), 32'd0);
    check("postrst_regWrite", 32'(regWrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 register file in the pipelined MIPS core.
- Shares that port between two writers: the WB stage (highest priority) and the multi-cycle multiply/divide unit (MDU, valid/ready handshake).
- Keeps a scoreboard of registers with outstanding MDU results and raises hazard stalls to ID.
- Includes a starvation guard that freezes WB for one cycle so a waiting MDU result can retire.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- STARVE_LIMIT, 4, consecutive lost MDU cycles before WB is forced to yield (range 1..15)
- MAX_PENDING, 4, maximum outstanding MDU operations

Ports:
- clock_in  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wbValid  in  1  WB stage write request
- wbReg  in  ADDR_W  WB destination
- wbData  in  DATA_W  WB data
- mduValid  in  1  MDU result valid; held with mduReg/mduData until transfer
- mduReg  in  ADDR_W  MDU destination
- mduData  in  DATA_W  MDU result
- mduReady  out  1  MDU result accepted this cycle
- issueValid  in  1  ID issues an MDU op
- issueReg  in  ADDR_W  destination of the issued op
- checkReg1  in  ADDR_W  ID source operand 1
- checkReg2  in  ADDR_W  ID source operand 2
- hazardStall  out  1  freeze IF/ID, combinational
- wbStall  out  1  freeze EX/MEM/WB, registered
- regWrite  out  1  to register file
- writeReg  out  ADDR_W  to register file
- writeData  out  DATA_W  to register file
- pendingCount  out  3  outstanding MDU ops

Behaviour:
- Reset (async, reset_n=0): regWrite=0, writeReg=0, writeData=0, wbStall=0, pendingCount=0, busy[31:0]=0, starve counter=0, state=ARB. Any in-flight MDU result is discarded.
- States:
  - ARB: WB wins whenever wbValid=1; otherwise the MDU wins if mduValid=1. mduReady=mduValid & ~wbValid.
  - FORCE: wbStall=1 and mduReady=mduValid; WB is ignored (the pipeline holds it).
- Transitions:
  - ARB->FORCE when mduValid & wbValid and starve counter == STARVE_LIMIT-1.
  - FORCE->ARB after exactly one cycle.
  - If mduValid=0 in FORCE: return to ARB, no write (protocol violation tolerated).
- Starve counter: increments in ARB on each cycle with mduValid & ~mduReady. Clears on MDU transfer and on entering ARB from FORCE.
- Write port latency: the winner is registered onto regWrite/writeReg/writeData on the next edge, so there is 1 cycle of latency. The output holds the last data when idle; regWrite=0 when idle.
- Register 0: a winning write with destination 0 produces regWrite=0. The handshake still completes and the write still counts as an arbitration win.
- Scoreboard:
  - An accepted issue (issueValid & pendingCount<MAX_PENDING) sets busy[issueReg] (never bit 0) and increments pendingCount.
  - An MDU transfer clears busy[mduReg] and decrements pendingCount.
  - Issue and transfer in the same cycle: count unchanged. Same register in both: set wins.
- hazardStall = busy[checkReg1] | busy[checkReg2] | (issueValid & pendingCount==MAX_PENDING) | (wbValid & busy[wbReg]) (WAW). Bit 0 reads as 0.
- An issue while hazardStall=1 is not accepted.
- An MDU transfer while pendingCount==0 is an error: count saturates at 0.

Decomposition:
- Shared package: ADDR_W, DATA_W, state encoding ARB=1'b0 / FORCE=1'b1, and the REG_ZERO constant.
- One natural sub-module: regfile_scoreboard, containing the busy vector, pendingCount and the hazard compare logic.
- Arbiter FSM and output register stay in the top level.

Test Plan:
- Reset mid-operation: issueReg=5'd8, then assert reset_n=0 asynchronously -> busy cleared, pendingCount=0, regWrite=0 immediately, before the next clock edge.
- WB alone: wbValid=1, wbReg=5'b10101, wbData=32'hFFFF0000 -> next cycle regWrite=1, writeReg=21, writeData=32'hFFFF0000. Then wbReg=0 -> regWrite=0.
- Scoreboard: issueReg=10, then checkReg1=10 -> hazardStall=1, pendingCount=1. Then mduValid=1, mduReg=10, mduData=32'h0000FFFF with wbValid=0 -> mduReady=1, next cycle writeReg=10, writeData=32'h0000FFFF, hazardStall=0, pendingCount=0.
- Starvation: wbValid=1 continuously with mduValid=1 -> mduReady=0 for 4 cycles, then FORCE: wbStall=1 and mduReady=1 for one cycle, MDU data written next cycle, then WB resumes.
- Full: 4 issues to regs 1..4 -> pendingCount=4. A 5th issueValid -> hazardStall=1 and count stays 4. Simultaneous issue and MDU retire at count 4 -> the issue is blocked that cycle and the count drops to 3.
- WAW: busy[12] set, wbValid=1, wbReg=12 -> hazardStall=1.
